// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 access codes and
// the data-memory access FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = word >> {byte_off, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h000000, shifted[7:0]};
      F3_HU:   result = {16'h0000, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-memory access controller: request/ack handshake with a
// variable-latency memory, byte lanes, load formatting and pipeline stall.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  LoadM_i,
  input  logic                  MemWriteM_i,
  input  logic [2:0]            Funct3M_i,
  input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  AdvanceM_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  StallM_o,
  output logic                  AccessFaultM_o
);

  mem_state_t            state_reg, state_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;

  logic [1:0]            byte_off;
  logic [1:0]            size;
  logic                  access;
  logic                  is_store;
  logic                  f3_legal;
  logic                  misaligned;
  logic                  fault;
  logic                  valid_access;
  logic                  req_active;
  logic                  ack_eff;
  logic [DATA_WIDTH-1:0] load_fmt;

  assign byte_off = ALUResultM_i[1:0];
  assign size     = Funct3M_i[1:0];
  assign access   = LoadM_i | MemWriteM_i;
  assign is_store = MemWriteM_i;

  always_comb begin
    f3_legal = 1'b0;
    case (Funct3M_i)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  end

  assign misaligned   = ((size == 2'b01) & byte_off[0]) |
                        ((size == 2'b10) & (byte_off != 2'b00));
  assign fault        = access & (~f3_legal | misaligned);
  assign valid_access = access & ~fault;

  // WAIT keeps requesting unconditionally: the frozen pipeline register holds the access.
  assign req_active = (state_reg == WAIT) | ((state_reg == IDLE) & valid_access);
  assign ack_eff    = rst_ni & req_active & dmem_ack_i;

  assign dmem_req_o     = rst_ni & req_active;
  assign StallM_o       = rst_ni & req_active & ~dmem_ack_i;
  assign AccessFaultM_o = fault;
  assign dmem_we_o      = is_store;
  assign dmem_addr_o    = {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_be_o = 4'b0000;
    case (size)
      2'b00:   dmem_be_o = 4'b0001 << byte_off;
      2'b01:   dmem_be_o = 4'b0011 << byte_off;
      2'b10:   dmem_be_o = 4'b1111;
      default: dmem_be_o = 4'b0000;
    endcase
  end

  // Each lane picks byte 0 (SB), byte gi%2 (SH) or its own byte (SW).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign dmem_wdata_o[8*gi +: 8] =
        (size == 2'b00) ? WriteDataM_i[7:0] :
        (size == 2'b01) ? WriteDataM_i[8*(gi%2) +: 8] :
                          WriteDataM_i[8*gi +: 8];
    end
  endgenerate

  mem_load_align u_load_align (
    .word     (dmem_rdata_i),
    .byte_off (byte_off),
    .funct3   (Funct3M_i),
    .result   (load_fmt)
  );

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    if (ack_eff) begin
      hold_next = load_fmt;
    end
    case (state_reg)
      IDLE: begin
        if (req_active) begin
          if (dmem_ack_i) state_next = AdvanceM_i ? IDLE : DONE;
          else            state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack_i) state_next = AdvanceM_i ? IDLE : DONE;
      end
      DONE: begin
        if (AdvanceM_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    ReadDataM_o = '0;
    if (ack_eff)                ReadDataM_o = load_fmt;
    else if (state_reg == DONE) ReadDataM_o = hold_reg;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized check of mem_access_unit against a behavioural
// model of the access rules and a bench-driven variable-latency memory.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        LoadM_i, MemWriteM_i, AdvanceM_i, dmem_ack_i;
  logic [2:0]  Funct3M_i;
  logic [31:0] ALUResultM_i, WriteDataM_i, dmem_rdata_i;
  logic        dmem_req_o, dmem_we_o, StallM_o, AccessFaultM_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, ReadDataM_o;
  logic [3:0]  dmem_be_o;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .LoadM_i        (LoadM_i),
    .MemWriteM_i    (MemWriteM_i),
    .Funct3M_i      (Funct3M_i),
    .ALUResultM_i   (ALUResultM_i),
    .WriteDataM_i   (WriteDataM_i),
    .AdvanceM_i     (AdvanceM_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .ReadDataM_o    (ReadDataM_o),
    .StallM_o       (StallM_o),
    .AccessFaultM_o (AccessFaultM_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access legality straight from the ISA rules.
  function automatic bit model_fault(input bit st, input int f3, input int addr);
    bit legal;
    int sz;
    legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    sz    = f3 % 4;
    return !legal || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
  endfunction

  function automatic int model_be(input int f3, input int off);
    case (f3 % 4)
      0:       return 1 << off;
      1:       return 3 << off;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] wd);
    case (f3 % 4)
      0:       return (wd % 256) * 32'h01010101;
      1:       return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * off));
    case (f3)
      0:       return (v % 256 >= 128)   ? (v % 256) - 256     : v % 256;
      1:       return (v % 65536 >= 32768) ? (v % 65536) - 65536 : v % 65536;
      4:       return v % 256;
      5:       return v % 65536;
      default: return v;
    endcase
  endfunction

  task automatic clear_inputs();
    LoadM_i = 0; MemWriteM_i = 0; Funct3M_i = 0;
    ALUResultM_i = 0; WriteDataM_i = 0;
    AdvanceM_i = 1; dmem_ack_i = 0; dmem_rdata_i = $urandom;
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int lat, input int hold);
    bit          flt;
    int          off;
    logic [31:0] exp_rd;
    flt    = model_fault(st, int'(f3), int'(addr[15:0]));
    off    = int'(addr[1:0]);
    exp_rd = model_load(int'(f3), off, rd);
    txn++;
    $display("txn %0d ld=%0b st=%0b f3=%0d addr=0x%08h wd=0x%08h rd=0x%08h lat=%0d hold=%0d fault=%0b",
             txn, ld, st, f3, addr, wd, rd, lat, hold, flt);
    LoadM_i = ld; MemWriteM_i = st; Funct3M_i = f3;
    ALUResultM_i = addr; WriteDataM_i = wd;
    if (flt) begin
      AdvanceM_i = 1; dmem_ack_i = 0;
      @(negedge clk_i);
      check("fault_flag", 32'(AccessFaultM_o), 32'd1);
      check("fault_req", 32'(dmem_req_o), 32'd0);
      check("fault_stall", 32'(StallM_o), 32'd0);
      check("fault_rdata", ReadDataM_o, 32'd0);
      @(posedge clk_i); #1;
      clear_inputs();
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      dmem_ack_i   = (k == lat);
      dmem_rdata_i = (k == lat) ? rd : $urandom;
      AdvanceM_i   = (k == lat) && (hold == 0);
      @(negedge clk_i);
      check("req", 32'(dmem_req_o), 32'd1);
      check("fault_clear", 32'(AccessFaultM_o), 32'd0);
      check("we", 32'(dmem_we_o), 32'(st));
      check("addr", dmem_addr_o, {addr[31:2], 2'b00});
      check("be", 32'(dmem_be_o), 32'(model_be(int'(f3), off)));
      if (st) check("wdata", dmem_wdata_o, model_wdata(int'(f3), wd));
      check("stall", 32'(StallM_o), 32'(k < lat));
      if (k < lat) check("rdata_wait", ReadDataM_o, 32'd0);
      else if (!st) check("rdata_ack", ReadDataM_o, exp_rd);
      @(posedge clk_i); #1;
    end
    for (int h = 1; h <= hold; h++) begin
      dmem_ack_i   = 0;
      dmem_rdata_i = $urandom;
      AdvanceM_i   = (h == hold);
      @(negedge clk_i);
      check("done_req", 32'(dmem_req_o), 32'd0);
      check("done_stall", 32'(StallM_o), 32'd0);
      if (!st) check("done_rdata", ReadDataM_o, exp_rd);
      @(posedge clk_i); #1;
    end
    clear_inputs();
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    check("idle_req", 32'(dmem_req_o), 32'd0);
    check("idle_stall", 32'(StallM_o), 32'd0);
    check("idle_rdata", ReadDataM_o, 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] addr;
    clear_inputs();
    rst_ni = 0;
    // Valid load presented during reset must not request.
    LoadM_i = 1; Funct3M_i = 3'b010; ALUResultM_i = 32'h100;
    #12;
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_stall", 32'(StallM_o), 32'd0);
    check("rst_rdata", ReadDataM_o, 32'd0);
    clear_inputs();
    @(posedge clk_i); #1;
    rst_ni = 1;
    idle_cycle();

    run_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    run_access(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 3, 0);
    run_access(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 3, 0);
    run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1, 0);
    run_access(1, 0, 3'b010, 32'h101, 0, 32'h0, 0, 0);
    run_access(0, 1, 3'b011, 32'h100, 32'h55, 32'h0, 0, 0);
    run_access(1, 1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0);
    run_access(1, 0, 3'b101, 32'h202, 0, 32'h9ABC1234, 0, 2);
    idle_cycle();
    run_access(1, 0, 3'b001, 32'h302, 0, 32'h8001FFFF, 2, 1);

    // Reset pulsed while waiting for the memory.
    LoadM_i = 1; Funct3M_i = 3'b010; ALUResultM_i = 32'h400;
    AdvanceM_i = 0; dmem_ack_i = 0;
    @(negedge clk_i);
    check("pre_rst_stall", 32'(StallM_o), 32'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("wait_req", 32'(dmem_req_o), 32'd1);
    #1 rst_ni = 0;
    #1;
    check("midrst_req", 32'(dmem_req_o), 32'd0);
    check("midrst_stall", 32'(StallM_o), 32'd0);
    clear_inputs();
    dmem_ack_i = 1;
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(negedge clk_i);
    check("late_ack_req", 32'(dmem_req_o), 32'd0);
    check("late_ack_rdata", ReadDataM_o, 32'd0);
    @(posedge clk_i); #1;
    dmem_ack_i = 0;
    run_access(1, 0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 1, 0);

    for (int n = 0; n < 60; n++) begin
      st   = ($urandom_range(0, 2) == 0);
      ld   = !st || ($urandom_range(0, 3) == 0);
      f3   = ($urandom_range(0, 5) == 0) ? 3'($urandom) :
             (st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 6));
      if (!st && f3 == 3'd3) f3 = 3'd4;
      addr = {$urandom_range(0, 255), 2'b00} +
             (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) :
              (f3[1:0] == 2'b00 ? 32'($urandom_range(0, 3)) :
               f3[1:0] == 2'b01 ? 32'(2 * $urandom_range(0, 1)) : 32'd0));
      run_access(ld, st, f3, addr, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
